// File: rtl/and16_ctrl_pkg.sv
// Shared definitions for the shared 16-bit AND arbiter slice.
// Holds the datapath width, FSM state encoding and requester IDs so that the
// arbiter, its interface and any checker agree on a single set of values.
package and16_ctrl_pkg;

  localparam int DATA_W = 16;

  // Two-state controller: IDLE accepts a request, EXEC produces the result.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  // Requester identifiers, also used as the last-grant pointer value.
  typedef enum logic {
    REQ_ID0 = 1'b0,
    REQ_ID1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/shared_and16_arbiter_if.sv
// Bundle of the two requester channels plus the shared result bus.
//
// Handshake: each req is a level request. The arbiter samples req at a rising
// edge while idle; a one-cycle gnt pulse in the following cycle means the
// operands were captured and the requester may change them. One cycle later a
// one-cycle done pulse marks result valid for that requester. Requests seen
// while busy are ignored, not queued; a requester that still wants service
// after done must keep req high.
//
// Modports:
//   master - requester side: drives req/a/b, observes gnt/done/result/busy
//   slave  - arbiter side:   observes req/a/b, drives gnt/done/result/busy
interface shared_and16_arbiter_if;
  import and16_ctrl_pkg::*;

  logic              req0;
  logic [DATA_W-1:0] a0;
  logic [DATA_W-1:0] b0;
  logic              req1;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] result;
  logic              busy;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, done0, done1, result, busy
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, done0, done1, result, busy
  );

endinterface

// File: rtl/student_and16.sv
// Existing combinational 16-bit bitwise AND cell.
// Ports:
//   a, b : 16-bit operands
//   y    : a AND b
module student_and16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  assign y = a & b;

endmodule

// File: rtl/shared_and16_arbiter.sv
// Two-requester round-robin arbiter in front of a single 16-bit AND unit.
//
// Ports:
//   clk          : single clock, rising edge
//   rst_n        : synchronous active-low reset
//   req0/a0/b0   : requester 0 level request and operands
//   req1/a1/b1   : requester 1 level request and operands
//   gnt0/gnt1    : one-cycle pulse, operands of that requester captured
//   done0/done1  : one-cycle pulse, result valid for that requester
//   result       : registered AND of the captured operands, held between dones
//   busy         : high while an operation is in flight (EXEC)
//
// Timing: req sampled at edge N -> gnt in cycle N+1 -> done/result in N+2.
// The edge that ends the done cycle can accept the next request.
module shared_and16_arbiter
  import and16_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic              req1,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  state_t            state;
  req_id_t           last_id;   // requester granted most recently
  req_id_t           owner;     // requester of the operation in flight
  req_id_t           winner;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] and_y;

  // A lone request always wins; on contention the one not granted last wins.
  always_comb begin
    winner = REQ_ID0;
    if (req0 && req1) begin
      winner = (last_id == REQ_ID0) ? REQ_ID1 : REQ_ID0;
    end else if (req1) begin
      winner = REQ_ID1;
    end
  end

  student_and16 u_and (
    .a (op_a),
    .b (op_b),
    .y (and_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      last_id <= REQ_ID1;   // makes requester 0 the favoured one
      owner   <= REQ_ID0;
      op_a    <= '0;
      op_b    <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      result  <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (req0 || req1) begin
            op_a    <= (winner == REQ_ID1) ? a1 : a0;
            op_b    <= (winner == REQ_ID1) ? b1 : b0;
            owner   <= winner;
            last_id <= winner;
            gnt0    <= (winner == REQ_ID0);
            gnt1    <= (winner == REQ_ID1);
            busy    <= 1'b1;
            state   <= ST_EXEC;
          end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            busy <= 1'b0;
          end
        end
        ST_EXEC: begin
          // Requests are deliberately not looked at here.
          result <= and_y;
          done0  <= (owner == REQ_ID0);
          done1  <= (owner == REQ_ID1);
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_and16_arbiter.sv
// Self-checking bench for shared_and16_arbiter.
// A reference model samples the request inputs at each rising edge and, from
// the service rules (one operation per two cycles, round-robin on contention,
// requester 0 favoured after reset), schedules the expected grant and done
// events with their cycle stamps. A monitor compares every output #1 after
// each rising edge against whatever is scheduled for that cycle.
module tb_shared_and16_arbiter;
  import and16_ctrl_pkg::*;

  typedef struct {
    int          cyc;
    int          id;
    logic [15:0] res;
  } event_t;

  logic clk;
  logic rst_n;

  shared_and16_arbiter_if bus ();

  shared_and16_arbiter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (bus.req0),
    .a0     (bus.a0),
    .b0     (bus.b0),
    .req1   (bus.req1),
    .a1     (bus.a1),
    .b1     (bus.b1),
    .gnt0   (bus.gnt0),
    .gnt1   (bus.gnt1),
    .done0  (bus.done0),
    .done1  (bus.done1),
    .result (bus.result),
    .busy   (bus.busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  event_t      gnt_q[$];
  event_t      done_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          favour = 0;     // requester that wins on contention
  int          free_at = 0;    // first edge at which a request can be taken
  logic [15:0] exp_result = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  always @(posedge clk) begin
    int     w;
    event_t e;
    cyc++;
    if (!rst_n) begin
      gnt_q.delete();
      done_q.delete();
      favour     = 0;
      free_at    = cyc + 1;
      exp_result = 16'h0000;
    end else if (cyc >= free_at && (bus.req0 || bus.req1)) begin
      if (bus.req0 && bus.req1) w = favour;
      else w = bus.req1 ? 1 : 0;
      favour = 1 - w;
      e.id  = w;
      e.res = (w == 1) ? (bus.a1 & bus.b1) : (bus.a0 & bus.b0);
      e.cyc = cyc;
      gnt_q.push_back(e);
      e.cyc = cyc + 1;
      done_q.push_back(e);
      free_at = cyc + 2;
    end
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic eg0, eg1, ed0, ed1;
    #1;
    eg0 = 1'b0; eg1 = 1'b0; ed0 = 1'b0; ed1 = 1'b0;
    if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
      eg0 = (gnt_q[0].id == 0);
      eg1 = (gnt_q[0].id == 1);
      void'(gnt_q.pop_front());
    end
    if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
      ed0 = (done_q[0].id == 0);
      ed1 = (done_q[0].id == 1);
      exp_result = done_q[0].res;
      void'(done_q.pop_front());
    end
    chk("gnt0",   {31'b0, bus.gnt0},  {31'b0, eg0});
    chk("gnt1",   {31'b0, bus.gnt1},  {31'b0, eg1});
    chk("done0",  {31'b0, bus.done0}, {31'b0, ed0});
    chk("done1",  {31'b0, bus.done1}, {31'b0, ed1});
    chk("busy",   {31'b0, bus.busy},  {31'b0, eg0 | eg1});
    chk("result", {16'b0, bus.result}, {16'b0, exp_result});
  end

  // ---------------- driver ----------------
  task automatic drive(input logic r0, input logic [15:0] xa0, input logic [15:0] xb0,
                       input logic r1, input logic [15:0] xa1, input logic [15:0] xb1);
    bus.req0 = r0; bus.a0 = xa0; bus.b0 = xb0;
    bus.req1 = r1; bus.a1 = xa1; bus.b1 = xb1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle(n);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
    bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
    @(negedge clk);
    do_reset(2);
    idle(2);

    // Lone requester 0.
    drive(1'b1, 16'hFFFF, 16'h0F0F, 1'b0, 16'h0, 16'h0);
    idle(3);

    // Simultaneous requests right after reset: 0 first, then 1.
    do_reset(1);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'hAAAA, 16'hFFFF, 1'b1, 16'h1234, 16'h00FF);
    idle(3);

    // Sustained contention: strict alternation.
    for (int i = 0; i < 16; i++)
      drive(1'b1, 16'($urandom), 16'($urandom), 1'b1, 16'($urandom), 16'($urandom));
    idle(3);

    // Reset during EXEC, then contention must favour requester 0.
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0, 16'h0);
    do_reset(1);
    drive(1'b1, 16'h5A5A, 16'hF0F0, 1'b1, 16'hFFFF, 16'h1111);
    idle(3);

    // Operands change in the grant cycle; captured values must be used.
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0, 16'h0);
    idle(3);

    // req1 raised while busy and dropped before idle: ignored.
    drive(1'b1, 16'h1357, 16'hFFFF, 1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'hFFFF, 16'hFFFF);
    idle(4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      drive(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    end
    rst_n = 1'b1;
    idle(5);

    chk("gnt_q_drained",  gnt_q.size(),  0);
    chk("done_q_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_and16_arbiter.md
SHARED_AND16_ARBITER -- requirements
Module: shared_and16_arbiter

Interface
REQ-001 SHALL have no parameters; data width is fixed at 16 bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port: req0  input  1  requester 0 operation request, level.
REQ-005 SHALL have port: a0, b0  input  16 each  requester 0 operands.
REQ-006 SHALL have port: req1  input  1  requester 1 operation request, level.
REQ-007 SHALL have port: a1, b1  input  16 each  requester 1 operands.
REQ-008 SHALL have port: gnt0, gnt1  output  1 each  one-cycle grant pulse; operands were captured.
REQ-009 SHALL have port: done0, done1  output  1 each  one-cycle pulse; result valid for that requester.
REQ-010 SHALL have port: result  output  16  registered bitwise AND of the granted operands.
REQ-011 SHALL have port: busy  output  1  high while an operation is in flight (state EXEC).

Function
REQ-012 SHALL implement a two-state FSM: IDLE and EXEC.
REQ-013 In IDLE with at least one req high at an edge, SHALL capture the winner's a/b into operand registers, go to EXEC, and raise that requester's gnt for exactly the next cycle.
REQ-014 In EXEC, at the next edge SHALL register op_a AND op_b into result, raise the same requester's done for exactly the next cycle, and return to IDLE.
REQ-015 Latency: req sampled at edge N -> gnt high in cycle N+1 -> done and result valid in cycle N+2.
REQ-016 Throughput: at most one operation per 2 cycles; a new request SHALL be sampled in the cycle done is high.
REQ-017 req inputs SHALL be ignored in EXEC; requests are not queued.
REQ-018 Arbitration SHALL be round-robin via a last-grant pointer, updated on every grant.
REQ-019 When only one req is high, it SHALL win regardless of the pointer.
REQ-020 When both are high, the requester not granted last SHALL win; after reset the pointer SHALL favour requester 0.
REQ-021 Operand changes after capture SHALL NOT affect result.
REQ-022 result SHALL hold its value between done pulses.
REQ-023 gnt0/gnt1 SHALL never be high together; the same holds for done0/done1.
REQ-024 busy SHALL be high exactly in the cycles gnt is high.

Reset
REQ-025 With rst_n low at an edge, SHALL go to IDLE with gnt0=gnt1=done0=done1=busy=0, result=16'h0000, operand registers=0, and the pointer favouring requester 0.
REQ-026 Reset in EXEC SHALL abort the operation: no done pulse and result=0.
REQ-027 The first request SHALL be accepted at the first edge with rst_n high.

Structure
REQ-028 State encodings, width constant (16) and requester IDs SHALL live in shared package and16_ctrl_pkg.
REQ-029 The AND datapath SHALL be one instance of the existing 16-bit AND module (student_and16) fed from the operand registers; no behavioural & operator on data.
REQ-030 Arbitration, FSM and output registers SHALL remain in shared_and16_arbiter; no further sub-modules.

Verification
REQ-031 Only req0 is high with a0=FFFF, b0=0F0F at edge N -> gnt0 in N+1, done0 in N+2, result=0F0F, and gnt1/done1 stay 0.
REQ-032 After reset, req0 and req1 are both high with a0=AAAA, b0=FFFF, a1=1234, b1=00FF -> gnt0 N+1, done0 N+2 with result AAAA, then gnt1 N+3, done1 N+4 with result 0034.
REQ-033 Both reqs are held high for 8 operations -> grants alternate 0,1,0,1..., with one gnt every 2 cycles and no overlap.
REQ-034 rst_n is pulsed low in an EXEC cycle -> no done, result=0000, busy=0; the next simultaneous request grants requester 0.
REQ-035 a0/b0 change to 0000 in the gnt0 cycle after capturing FFFF/FFFF -> result=FFFF.
REQ-036 req1 is raised while busy and dropped before IDLE -> no gnt1 or done1.
